// File: rtl/ins_dec.sv
// ins_dec: splits the selected IMEM half-word into decode fields and keeps a sticky illegal-opcode flag.
package simple_processor_pkg;
    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        OR    = 4'd3,
        XOR   = 4'd4,
        NOT   = 4'd5,
        ADDI  = 4'd6,
        SLL   = 4'd7,
        SLR   = 4'd8,
        SLLI  = 4'd9,
        SLRI  = 4'd10,
        LOAD  = 4'd11,
        STORE = 4'd12
    } func_t;
endpackage

module ins_dec
    import simple_processor_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  imem_ack_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    output func_t                 func_o,
    output logic                  we_o,
    output logic [2:0]            rd_addr_o,
    output logic [2:0]            rs1_addr_o,
    output logic [2:0]            rs2_addr_o,
    output logic [5:0]            imm_o,
    output logic                  valid_pc_o,
    output logic                  illegal_o
);
    logic [INSTR_WIDTH-1:0] instr;
    logic [3:0]             opc;
    logic                   illegal_op;
    logic                   unused_addr;

    assign unused_addr = ^{imem_addr_i[ADDR_WIDTH-1:2], imem_addr_i[0]};

    // A missing ack turns the fetch into an all-zero bubble.
    always_comb begin
        instr = imem_ack_i ? (imem_addr_i[1] ? imem_rdata_i[2*INSTR_WIDTH-1:INSTR_WIDTH]
                                             : imem_rdata_i[INSTR_WIDTH-1:0]) : '0;
        opc = instr[3:0];
        func_o = func_t'(opc);
        imm_o = instr[9:4];
        rs2_addr_o = instr[9:7];
        rs1_addr_o = instr[12:10];
        rd_addr_o = instr[15:13];
        valid_pc_o = imem_ack_i && (opc <= 4'd12);
        we_o = imem_ack_i && (opc <= 4'd11);
        illegal_op = imem_ack_i && (opc >= 4'd13);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)
            illegal_o <= 1'b0;
        else if (illegal_op)
            illegal_o <= 1'b1;
    end
endmodule

// File: tb/tb_ins_dec.sv
// tb_ins_dec: directed and random decode vectors checked through an expected-value queue.
module tb_ins_dec;
    import simple_processor_pkg::*;

    logic        clk;
    logic        arst;
    logic [31:0] rdata;
    logic        ack;
    logic [31:0] addr;
    func_t       func;
    logic        we;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [5:0]  imm;
    logic        vpc;
    logic        ill;

    typedef struct {
        int          id;
        logic [21:0] exp;
    } item_t;

    item_t q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    ins_dec dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .imem_rdata_i (rdata),
        .imem_ack_i   (ack),
        .imem_addr_i  (addr),
        .func_o       (func),
        .we_o         (we),
        .rd_addr_o    (rd),
        .rs1_addr_o   (rs1),
        .rs2_addr_o   (rs2),
        .imm_o        (imm),
        .valid_pc_o   (vpc),
        .illegal_o    (ill)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [21:0] mk(input logic [3:0] f, input logic w, input logic [2:0] d,
                                       input logic [2:0] s1, input logic [2:0] s2,
                                       input logic [5:0] im, input logic v, input logic il);
        return {f, w, d, s1, s2, im, v, il};
    endfunction

    // Inputs change just after the rising edge; the monitor checks them at the following falling edge.
    task automatic apply(input int id, input logic r, input logic a, input logic [31:0] ad,
                         input logic [31:0] rd_word, input logic [21:0] exp);
        item_t it;
        @(posedge clk);
        #1;
        arst = r;
        ack = a;
        addr = ad;
        rdata = rd_word;
        it.id = id;
        it.exp = exp;
        q.push_back(it);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            item_t it;
            logic [21:0] act;
            it = q.pop_front();
            act = {4'(func), we, rd, rs1, rs2, imm, vpc, ill};
            n_vec++;
            if (act !== it.exp) begin
                n_bad++;
                $display("FAIL vec %0d: got %h expected %h", it.id, act, it.exp);
            end
        end
    end

    initial begin
        logic [15:0] instr;
        logic [31:0] ra;
        logic [31:0] rw;
        logic        ill_m;
        arst = 1'b1;
        ack = 1'b0;
        addr = '0;
        rdata = '0;
        apply(0, 1'b1, 1'b0, 32'h0, 32'h0, mk(4'd0, 0, 3'd0, 3'd0, 3'd0, 6'h00, 0, 0));
        apply(1, 1'b0, 1'b1, 32'h0, 32'h0000_E946, mk(4'd6, 1, 3'd7, 3'd2, 3'd2, 6'h14, 1, 0));
        apply(2, 1'b0, 1'b1, 32'h2, 32'h300C_FFFF, mk(4'd12, 0, 3'd1, 3'd4, 3'd0, 6'h00, 1, 0));
        apply(3, 1'b0, 1'b1, 32'h0, 32'h0000_000D, mk(4'd13, 0, 3'd0, 3'd0, 3'd0, 6'h00, 0, 0));
        apply(4, 1'b0, 1'b1, 32'h0, 32'h1234_5670, mk(4'd0, 1, 3'd2, 3'd5, 3'd4, 6'h27, 1, 1));
        apply(5, 1'b0, 1'b0, 32'h2, 32'hFFFF_FFFF, mk(4'd0, 0, 3'd0, 3'd0, 3'd0, 6'h00, 0, 1));
        apply(6, 1'b0, 1'b1, 32'h3, 32'h000E_0000, mk(4'd14, 0, 3'd0, 3'd0, 3'd0, 6'h00, 0, 1));
        apply(7, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_FFFF, mk(4'd15, 0, 3'd7, 3'd7, 3'd7, 6'h3F, 0, 1));
        apply(8, 1'b1, 1'b1, 32'h0, 32'h0000_E946, mk(4'd6, 1, 3'd7, 3'd2, 3'd2, 6'h14, 1, 0));
        apply(9, 1'b1, 1'b1, 32'h0, 32'h0000_000D, mk(4'd13, 0, 3'd0, 3'd0, 3'd0, 6'h00, 0, 0));
        apply(10, 1'b0, 1'b1, 32'h0, 32'h0000_000D, mk(4'd13, 0, 3'd0, 3'd0, 3'd0, 6'h00, 0, 0));
        apply(11, 1'b0, 1'b1, 32'h2, 32'h300C_0000, mk(4'd12, 0, 3'd1, 3'd4, 3'd0, 6'h00, 1, 1));
        apply(12, 1'b0, 1'b1, 32'h1, 32'h0000_E94B, mk(4'd11, 1, 3'd7, 3'd2, 3'd2, 6'h14, 1, 1));
        apply(13, 1'b1, 1'b0, 32'h0, 32'h0000_000F, mk(4'd0, 0, 3'd0, 3'd0, 3'd0, 6'h00, 0, 0));
        ill_m = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rw = $urandom;
            instr = ra[1] ? rw[31:16] : rw[15:0];
            apply(100 + i, 1'b0, 1'b1, ra, rw,
                  mk(instr[3:0], instr[3:0] <= 4'd11, instr[15:13], instr[12:10], instr[9:7],
                     instr[9:4], instr[3:0] <= 4'd12, ill_m));
            ill_m = ill_m | (instr[3:0] >= 4'd13);
        end
        for (int i = 0; i < 20 && q.size() != 0; i++)
            @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ins_dec.md
# ins_dec

Instruction decoder of the simple processor, between the instruction memory (IMEM) interface and the register file / ALU. It selects the 16-bit instruction from the 32-bit IMEM read word using the fetch address and splits it into function code, register addresses and immediate. It also generates the register-file write enable and the PC-valid indication. All decode outputs are combinational. The only state is a sticky illegal-opcode flag.

## Interface
- DATA_WIDTH, 32, IMEM read-data width; holds two instructions.
- ADDR_WIDTH, 32, IMEM byte-address width.
- INSTR_WIDTH, 16, instruction width.
- clk_i  in  1  clock; used only by the illegal-opcode flag.
- arst_i  in  1  asynchronous, active-high reset.
- imem_rdata_i  in  DATA_WIDTH  IMEM read word.
- imem_ack_i  in  1  IMEM acknowledge; 1 selects imem_rdata_i, 0 forces the instruction to 0.
- imem_addr_i  in  ADDR_WIDTH  fetch address; only bit 1 is used.
- func_o  out  4 (func_t)  decoded function code.
- we_o  out  1  register-file write enable.
- rd_addr_o  out  3  destination register address.
- rs1_addr_o  out  3  source register 1 address.
- rs2_addr_o  out  3  source register 2 address.
- imm_o  out  6  unextended immediate.
- valid_pc_o  out  1  instruction is a legal opcode; the PC may advance.
- illegal_o  out  1  sticky flag: an illegal opcode has been acknowledged since reset.

## Operation
- Instruction select:
  - instr = imem_addr_i[1] ? imem_rdata_i[31:16] : imem_rdata_i[15:0].
  - When imem_ack_i=0, instr = 16'h0000.
- Field extraction is unconditional, for every opcode:
  - func_o = instr[3:0], cast to func_t.
  - imm_o = instr[9:4].
  - rs2_addr_o = instr[9:7]. This overlaps imm_o by design.
  - rs1_addr_o = instr[12:10].
  - rd_addr_o = instr[15:13].
- func_t encoding (simple_processor_pkg):
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, ADDI=6, SLL=7.
  - SLR=8, SLLI=9, SLRI=10, LOAD=11, STORE=12.
  - Codes 13–15 are illegal.
- valid_pc_o = 1 for any of the 13 legal opcodes, 0 for codes 13–15.
- we_o = 1 for ADD, SUB, AND, OR, XOR, NOT, ADDI, SLL, SLR, SLLI, SLRI, LOAD.
- we_o = 0 for STORE and for illegal codes.
- Bubble: imem_ack_i=0 forces we_o=0 and valid_pc_o=0. The field outputs still show the zeroed instruction, so func_o=ADD and all addresses and immediate are 0.
- illegal_o:
  - Set on a rising clk_i edge when imem_ack_i=1 and instr[3:0] is 13–15.
  - Holds at 1 until arst_i.
  - Never cleared by a legal instruction.

## Timing
- Decode outputs (func_o, we_o, valid_pc_o, rd/rs1/rs2_addr_o, imm_o) are purely combinational.
  - Zero-cycle latency.
  - Valid in the same cycle the inputs change.
  - Unaffected by clk_i and arst_i.
- illegal_o is a flop.
  - Goes to 0 asynchronously when arst_i=1.
  - Rises on the first clk_i edge after an acknowledged illegal opcode, one cycle of latency.
  - Reset asserted mid-run clears it immediately.
  - An illegal opcode present on the same edge that reset deasserts is captured only if arst_i is already low at that edge.
- imem_addr_i[0] and bits [ADDR_WIDTH-1:2] are ignored. An unaligned address selects a half-word only via bit 1.
- No handshake. imem_ack_i is purely a data-select or bubble qualifier.

## Test plan
- ack=1, addr=0x0, rdata=0x0000_E946 (low half-word 0xE946):
  - func_o=ADDI(6), rd=7, rs1=2, imm=0x14, rs2=2.
  - we_o=1, valid_pc_o=1.
- ack=1, addr=0x2, rdata=0x300C_FFFF:
  - upper half-word 0x300C is selected.
  - func_o=STORE, rd=1, rs1=4, rs2=0, imm=0.
  - we_o=0, valid_pc_o=1.
- ack=1, low-half opcode 13, 14 and 15 in turn:
  - valid_pc_o=0, we_o=0.
  - illegal_o goes 0→1 at the next clk_i edge and stays 1 while legal opcodes follow.
- ack=0 with any rdata:
  - all fields 0, func_o=ADD, we_o=0, valid_pc_o=0.
  - illegal_o unchanged.
- Assert arst_i while illegal_o=1: illegal_o goes to 0 with no clock edge. Decode outputs keep tracking their inputs throughout.
- 1000 cycles of random addr/rdata with ack=1:
  - every output matches the field equations above.
  - we_o and valid_pc_o match the opcode tables.
  - zero mismatches.
